bidir_bus_ctrl: RTL and testbench
=================================

BIDIR_BUS_CTRL -- requirements
Module: bidir_bus_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: width of the shared half-duplex bus and all data ports.
REQ-002 Parameter TURN_CYC, default 1, legal range 1..15: idle bus cycles inserted after every drive phase before any new transaction.
REQ-003 clk  input  1  single system clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wr_valid  input  1  write request; wr_data is valid while it is high.
REQ-006 wr_data  input  DATA_W  word to drive onto the bus.
REQ-007 wr_ready  output  1  controller can accept a write this cycle.
REQ-008 rd_req  input  1  single-cycle request to sample the bus.
REQ-009 rd_valid  output  1  one-cycle pulse; rd_data is valid.
REQ-010 rd_data  output  DATA_W  word captured from the bus.
REQ-011 oe  output  1  output enable to the downstream bidirectional buffer.
REQ-012 bus_out  output  DATA_W  data presented to the buffer's input.
REQ-013 bus_in  input  DATA_W  data returned from the buffer's output.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states are IDLE, DRIVE, TURN and SAMPLE, all encoded in registers.
REQ-016 wr_ready is 1 only in IDLE; a write handshake is wr_valid && wr_ready.
REQ-017 On a write handshake in cycle N, state becomes DRIVE at N+1 with oe=1 and bus_out=wr_data, both registered.
REQ-018 DRIVE lasts exactly one cycle, then moves to TURN with oe=0.
REQ-019 bus_out holds the last driven value in all states.
REQ-020 TURN lasts exactly TURN_CYC cycles, timed by a 4-bit down-counter, then returns to IDLE.
REQ-021 rd_req is honoured only in IDLE and is ignored in every other state.
REQ-022 When rd_req is honoured in cycle N, state is SAMPLE at N+1 and rd_data is registered from bus_in at the end of N+1.
REQ-023 rd_valid is high for exactly cycle N+2; the state returns to IDLE at N+2.
REQ-024 If a write handshake and rd_req occur in the same cycle, the write wins and the read is dropped.
REQ-025 Back-to-back reads need no turnaround, so a new read may be honoured at N+2.
REQ-026 A read honoured directly after a write's TURN phase sees oe=0 throughout SAMPLE.
REQ-027 oe is never 1 outside DRIVE, and is never 1 in the cycle immediately following DRIVE.

Reset
REQ-028 While rst=1, the state is forced to IDLE immediately, without waiting for a clock edge.
REQ-029 Reset values: oe=0, bus_out=0, rd_data=0, rd_valid=0, busy=0, turnaround counter=0, err=0.
REQ-030 Reset asserted mid-DRIVE drops oe within the same cycle; an aborted transaction is not replayed.
REQ-031 wr_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-032 When BIDIR_BUS_LOOPBACK_CHECK_EN is defined, an extra output err (1 bit) is added.
REQ-033 With the macro, in the cycle after DRIVE the block compares bus_in against bus_out; a mismatch sets err sticky until rst.
REQ-034 Without the macro, the err port, the comparator and the err register are absent, and all other behaviour is identical.

Structure
REQ-035 Shared package bidir_pkg holds the state enum, the DATA_W default and the TURN_CYC range limit.
REQ-036 The turnaround counter is a sub-module, bidir_turn_cnt: load, decrement, and a zero flag.
REQ-037 The controller and the existing bidirectional buffer share only oe, bus_out and bus_in.

Verification
REQ-038 Write: wr_data=0x5A, wr_valid for 1 cycle at N, TURN_CYC=1 -> oe=1 and bus_out=0x5A at N+1 only; wr_ready=0 at N+1..N+2; wr_ready=1 at N+3.
REQ-039 Read: bus_in=0xC3 and rd_req at N -> rd_valid=1 and rd_data=0xC3 at N+2; oe=0 throughout.
REQ-040 Collision: wr_valid=1 (0x11) and rd_req in the same cycle -> only the write executes; rd_valid never rises.
REQ-041 Turnaround: TURN_CYC=3, write then rd_req held every cycle -> the read is honoured no earlier than 4 cycles after the DRIVE cycle.
REQ-042 Async reset during DRIVE (rst pulse of 3 ns mid-cycle) -> oe=0 before the next clock edge; all outputs at reset values.
REQ-043 With BIDIR_BUS_LOOPBACK_CHECK_EN, force bus_in=0x00 while 0xFF is driven -> err=1 next cycle and stays 1 until rst.

Source files
------------

// File: rtl/bidir_pkg.sv
// Shared types and limits for the half-duplex bus controller.
package bidir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_TURN   = 2'd2,
      ST_SAMPLE = 2'd3
   } state_t;

   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned TURN_CYC_MIN = 1;
   localparam int unsigned TURN_CYC_MAX = 15;
   localparam int unsigned CNT_W        = 4;

endpackage

// File: rtl/bidir_turn_cnt.sv
// Turnaround down-counter: load, decrement, zero flag.
module bidir_turn_cnt import bidir_pkg::*; (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex bus controller: drive / turnaround / sample sequencing.
// Optional loopback checker enabled by BIDIR_BUS_LOOPBACK_CHECK_EN (adds err).
module bidir_bus_ctrl import bidir_pkg::*; #(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned TURN_CYC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ready,
   input  logic              rd_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              oe,
   output logic [DATA_W-1:0] bus_out,
   input  logic [DATA_W-1:0] bus_in,
   output logic              busy
`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
   ,output logic             err
`endif
);

   // Counter holds remaining TURN cycles minus one, so zero means last TURN cycle.
   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYC - 1);

   state_t state_q, state_d;
   logic   take_wr, capture, load_cnt, dec_cnt, cnt_zero;

   bidir_turn_cnt u_turn_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (load_cnt),
      .load_val (TURN_LOAD),
      .dec      (dec_cnt),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d  = state_q;
      take_wr  = 1'b0;
      capture  = 1'b0;
      load_cnt = 1'b0;
      dec_cnt  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A write beats a simultaneous read request; the read is dropped.
            if (wr_valid) begin
               take_wr = 1'b1;
               state_d = ST_DRIVE;
            end else if (rd_req) begin
               state_d = ST_SAMPLE;
            end
         end
         ST_DRIVE: begin
            load_cnt = 1'b1;
            state_d  = ST_TURN;
         end
         ST_TURN: begin
            if (cnt_zero) state_d = ST_IDLE;
            else          dec_cnt = 1'b1;
         end
         ST_SAMPLE: begin
            capture = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         oe       <= 1'b0;
         bus_out  <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         state_q  <= state_d;
         oe       <= (state_d == ST_DRIVE);
         rd_valid <= capture;
         if (take_wr) bus_out <= wr_data;
         if (capture) rd_data <= bus_in;
      end
   end

   assign wr_ready = (state_q == ST_IDLE);
   assign busy     = (state_q != ST_IDLE);

`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
   logic after_drive;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         after_drive <= 1'b0;
         err         <= 1'b0;
      end else begin
         after_drive <= (state_q == ST_DRIVE);
         if (after_drive && (bus_in != bus_out)) err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Scoreboarded bench for bidir_bus_ctrl; err checks when BIDIR_BUS_LOOPBACK_CHECK_EN is defined.
module tb_bidir_bus_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_valid, rd_req, wr_ready, rd_valid, oe, busy;
   logic [7:0] wr_data, rd_data, bus_out, bus_in;
   logic       wr_valid3, rd_req3, wr_ready3, rd_valid3, oe3, busy3;
   logic [7:0] wr_data3, rd_data3, bus_out3, bus_in3;
   logic [7:0] remote;
   logic       remote_en, force_bad;
`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
   logic       err, err3;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;
   logic [7:0]  wr_q[$];
   logic [7:0]  rd_q[$];
   logic [7:0]  exp_w, exp_r;

   always #5 clk = ~clk;

   // Bus model: the far side drives only when enabled; otherwise the bus keeps the last driven value.
   assign bus_in  = force_bad ? 8'h00 : ((oe || !remote_en) ? bus_out : remote);
   assign bus_in3 = bus_out3;

   bidir_bus_ctrl #(.DATA_W(8), .TURN_CYC(1)) dut (
      .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .oe(oe),
      .bus_out(bus_out), .bus_in(bus_in), .busy(busy)
`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
      , .err(err)
`endif
   );

   bidir_bus_ctrl #(.DATA_W(8), .TURN_CYC(3)) dut3 (
      .clk(clk), .rst(rst), .wr_valid(wr_valid3), .wr_data(wr_data3), .wr_ready(wr_ready3),
      .rd_req(rd_req3), .rd_valid(rd_valid3), .rd_data(rd_data3), .oe(oe3),
      .bus_out(bus_out3), .bus_in(bus_in3), .busy(busy3)
`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
      , .err(err3)
`endif
   );

   always @(negedge clk) begin
      if (!rst && oe) begin
         total++;
         if (wr_q.size() == 0) begin
            bad++; $display("FAIL sb_drive_unexpected got bus_out=%h exp=no drive", bus_out);
         end else begin
            exp_w = wr_q.pop_front();
            if (bus_out !== exp_w) begin bad++; $display("FAIL sb_drive_data got=%h exp=%h", bus_out, exp_w); end
         end
      end
      if (!rst && rd_valid) begin
         total++;
         if (rd_q.size() == 0) begin
            bad++; $display("FAIL sb_read_unexpected got rd_data=%h exp=no read", rd_data);
         end else begin
            exp_r = rd_q.pop_front();
            if (rd_data !== exp_r) begin bad++; $display("FAIL sb_read_data got=%h exp=%h", rd_data, exp_r); end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wr_valid = 1'b0; wr_data = '0; rd_req = 1'b0;
      wr_valid3 = 1'b0; wr_data3 = '0; rd_req3 = 1'b0;
      remote = '0; remote_en = 1'b0; force_bad = 1'b0;
      #22;
      total++; if (oe !== 1'b0)       begin bad++; $display("FAIL rst_oe got=%b exp=0", oe); end
      total++; if (bus_out !== 8'h00) begin bad++; $display("FAIL rst_bus_out got=%h exp=00", bus_out); end
      total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rst_rd_data got=%h exp=00", rd_data); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got=%b exp=0", rd_valid); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (busy3 !== 1'b0)    begin bad++; $display("FAIL rst_busy3 got=%b exp=0", busy3); end
`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
      total++; if (err !== 1'b0)      begin bad++; $display("FAIL rst_err got=%b exp=0", err); end
`endif
      drive_edge();
      rst = 1'b0;
      @(negedge clk);
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rst_wr_ready_after got=%b exp=1", wr_ready); end
   endtask

   task automatic test_write();
      drive_edge(); wr_valid = 1'b1; wr_data = 8'h5A; wr_q.push_back(8'h5A);
      @(negedge clk);
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_n got=%b exp=1", wr_ready); end
      drive_edge(); wr_valid = 1'b0; wr_data = 8'hEE;
      @(negedge clk);
      total++; if (oe !== 1'b1)       begin bad++; $display("FAIL wr_oe_n1 got=%b exp=1", oe); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_n1 got=%b exp=0", wr_ready); end
      total++; if (busy !== 1'b1)     begin bad++; $display("FAIL wr_busy_n1 got=%b exp=1", busy); end
      drive_edge(); @(negedge clk);
      total++; if (oe !== 1'b0)       begin bad++; $display("FAIL wr_oe_n2 got=%b exp=0", oe); end
      total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL wr_ready_n2 got=%b exp=0", wr_ready); end
      total++; if (bus_out !== 8'h5A) begin bad++; $display("FAIL wr_hold_n2 got=%h exp=5a", bus_out); end
      drive_edge(); @(negedge clk);
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL wr_ready_n3 got=%b exp=1", wr_ready); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL wr_busy_n3 got=%b exp=0", busy); end
      total++; if (bus_out !== 8'h5A) begin bad++; $display("FAIL wr_hold_n3 got=%h exp=5a", bus_out); end
   endtask

   task automatic test_read();
      drive_edge(); remote_en = 1'b1; remote = 8'hC3; rd_req = 1'b1; rd_q.push_back(8'hC3);
      @(negedge clk);
      drive_edge(); rd_req = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b1)     begin bad++; $display("FAIL rd_busy_n1 got=%b exp=1", busy); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_n1 got=%b exp=0", rd_valid); end
      total++; if (oe !== 1'b0)       begin bad++; $display("FAIL rd_oe_n1 got=%b exp=0", oe); end
      drive_edge(); remote = 8'h00;
      @(negedge clk);
      total++; if (rd_valid !== 1'b1) begin bad++; $display("FAIL rd_valid_n2 got=%b exp=1", rd_valid); end
      total++; if (rd_data !== 8'hC3) begin bad++; $display("FAIL rd_data_n2 got=%h exp=c3", rd_data); end
      total++; if (oe !== 1'b0)       begin bad++; $display("FAIL rd_oe_n2 got=%b exp=0", oe); end
      drive_edge(); @(negedge clk);
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_n3 got=%b exp=0", rd_valid); end
      remote_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic exp_v;
      for (int j = 0; j < 8; j++) begin
         drive_edge();
         rd_req    = (j < 6);
         remote_en = 1'b1;
         remote    = 8'(8'h10 + j);
         if (j < 6 && (j % 2) == 0) rd_q.push_back(8'(8'h10 + j + 1));
         @(negedge clk);
         exp_v = (j == 2 || j == 4 || j == 6);
         total++;
         if (rd_valid !== exp_v) begin bad++; $display("FAIL b2b_rd_valid cyc=%0d got=%b exp=%b", j, rd_valid, exp_v); end
      end
      rd_req = 1'b0; remote_en = 1'b0;
   endtask

   task automatic test_collision();
      drive_edge(); wr_valid = 1'b1; wr_data = 8'h11; rd_req = 1'b1; wr_q.push_back(8'h11);
      @(negedge clk);
      for (int j = 0; j < 5; j++) begin
         drive_edge(); wr_valid = 1'b0; rd_req = 1'b0;
         @(negedge clk);
         total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL coll_rd_valid cyc=%0d got=%b exp=0", j, rd_valid); end
         total++; if (oe !== (j == 0)) begin bad++; $display("FAIL coll_oe cyc=%0d got=%b exp=%b", j, oe, (j == 0)); end
      end
   endtask

   task automatic test_read_after_write();
      drive_edge(); wr_valid = 1'b1; wr_data = 8'h3C; wr_q.push_back(8'h3C);
      @(negedge clk);
      // j=1 DRIVE, j=2 TURN, j=3 IDLE honours read, j=4 SAMPLE, j=5 rd_valid
      for (int j = 1; j < 7; j++) begin
         drive_edge();
         wr_valid  = 1'b0;
         rd_req    = (j < 5);
         remote    = 8'h99;
         remote_en = (j >= 3);
         if (j == 3) rd_q.push_back(8'h99);
         @(negedge clk);
         if (j >= 2) begin
            total++; if (oe !== 1'b0) begin bad++; $display("FAIL raw_oe cyc=%0d got=%b exp=0", j, oe); end
         end
         total++; if (rd_valid !== (j == 5)) begin bad++; $display("FAIL raw_rd_valid cyc=%0d got=%b exp=%b", j, rd_valid, (j == 5)); end
      end
      rd_req = 1'b0; remote_en = 1'b0;
   endtask

   task automatic test_turnaround();
      drive_edge(); wr_valid3 = 1'b1; wr_data3 = 8'h77;
      @(negedge clk);
      // DRIVE at 1, TURN 2..4, IDLE 5 honours read, SAMPLE 6, rd_valid 7
      for (int j = 1; j < 9; j++) begin
         drive_edge();
         wr_valid3 = 1'b0;
         rd_req3   = (j < 6);
         @(negedge clk);
         total++; if (oe3 !== (j == 1)) begin bad++; $display("FAIL turn_oe cyc=%0d got=%b exp=%b", j, oe3, (j == 1)); end
         total++; if (busy3 !== (j <= 4 || j == 6)) begin bad++; $display("FAIL turn_busy cyc=%0d got=%b exp=%b", j, busy3, (j <= 4 || j == 6)); end
         total++; if (rd_valid3 !== (j == 7)) begin bad++; $display("FAIL turn_rd_valid cyc=%0d got=%b exp=%b", j, rd_valid3, (j == 7)); end
         if (j == 7) begin
            total++; if (rd_data3 !== 8'h77) begin bad++; $display("FAIL turn_rd_data got=%h exp=77", rd_data3); end
         end
      end
      rd_req3 = 1'b0;
   endtask

   task automatic test_reset_drive();
      drive_edge(); wr_valid = 1'b1; wr_data = 8'hA5;
      drive_edge(); wr_valid = 1'b0;
      total++; if (oe !== 1'b1) begin bad++; $display("FAIL rstd_oe_before got=%b exp=1", oe); end
      rst = 1'b1;
      #1;
      total++; if (oe !== 1'b0)       begin bad++; $display("FAIL rstd_oe got=%b exp=0", oe); end
      total++; if (bus_out !== 8'h00) begin bad++; $display("FAIL rstd_bus_out got=%h exp=00", bus_out); end
      total++; if (rd_data !== 8'h00) begin bad++; $display("FAIL rstd_rd_data got=%h exp=00", rd_data); end
      total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL rstd_rd_valid got=%b exp=0", rd_valid); end
      total++; if (busy !== 1'b0)     begin bad++; $display("FAIL rstd_busy got=%b exp=0", busy); end
      #2;
      rst = 1'b0;
      @(negedge clk);
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL rstd_wr_ready got=%b exp=1", wr_ready); end
      for (int j = 0; j < 3; j++) begin
         drive_edge(); @(negedge clk);
         total++; if (oe !== 1'b0) begin bad++; $display("FAIL rstd_replay cyc=%0d got=%b exp=0", j, oe); end
      end
   endtask

`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
   task automatic test_err();
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_clean got=%b exp=0", err); end
      drive_edge(); wr_valid = 1'b1; wr_data = 8'hFF; wr_q.push_back(8'hFF);
      @(negedge clk);
      drive_edge(); wr_valid = 1'b0; force_bad = 1'b1;
      @(negedge clk);
      drive_edge(); @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_early got=%b exp=0", err); end
      drive_edge(); force_bad = 1'b0;
      @(negedge clk);
      total++; if (err !== 1'b1) begin bad++; $display("FAIL err_set got=%b exp=1", err); end
      for (int j = 0; j < 3; j++) begin
         drive_edge(); @(negedge clk);
         total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky cyc=%0d got=%b exp=1", j, err); end
      end
      total++; if (err3 !== 1'b0) begin bad++; $display("FAIL err3_clean got=%b exp=0", err3); end
      drive_edge(); rst = 1'b1;
      drive_edge(); rst = 1'b0;
      @(negedge clk);
      total++; if (err !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", err); end
   endtask
`endif

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_collision();
      test_read_after_write();
      test_turnaround();
      test_reset_drive();
`ifdef BIDIR_BUS_LOOPBACK_CHECK_EN
      test_err();
`endif
      drive_edge(); @(negedge clk);
      total++; if (wr_q.size() != 0) begin bad++; $display("FAIL sb_wr_left got=%0d exp=0", wr_q.size()); end
      total++; if (rd_q.size() != 0) begin bad++; $display("FAIL sb_rd_left got=%0d exp=0", rd_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
